// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational yAlu between two requesters.
// Optional macro ALU_ARB_GRANT_CNT_EN adds saturating per-requester grant counters.
module yAlu (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    output logic [31:0] z,
    output logic        ex
);
    logic [31:0] w_b;
    logic [31:0] w_sum;

    // op[2] inverts b and supplies the carry-in, turning ADD into SUB
    always_comb begin
        w_b   = op[2] ? ~b : b;
        w_sum = a + w_b + {31'd0, op[2]};
        case (op[1:0])
            2'b00:   z = a & w_b;
            2'b01:   z = a | w_b;
            2'b10:   z = w_sum;
            default: z = {31'd0, ($signed(a) < $signed(b))};
        endcase
        ex = (z == 32'd0);
    end
endmodule

module alu_share_arbiter #(
    parameter bit RR_INIT = 1'b0,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [31:0]       req_a0,
    input  logic [31:0]       req_b0,
    input  logic [2:0]        req_op0,
    input  logic [31:0]       req_a1,
    input  logic [31:0]       req_b1,
    input  logic [2:0]        req_op1,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [31:0]       rsp_z,
    output logic              rsp_zero
`ifdef ALU_ARB_GRANT_CNT_EN
    ,
    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1
`endif
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_ptr;
    logic        r_owner;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [2:0]  r_op;
    logic [31:0] r_z;
    logic        r_zero;
    logic        w_grant_id;
    logic        w_accept;
    logic        w_rsp_done;
    logic [31:0] w_z;
    logic        w_ex;

    yAlu u_alu (.a(r_a), .b(r_b), .op(r_op), .z(w_z), .ex(w_ex));

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 2'b00;
        rsp_valid   = 2'b00;
        w_accept    = 1'b0;
        w_rsp_done  = 1'b0;
        w_grant_id  = (req_valid == 2'b11) ? ~r_ptr : req_valid[1];
        case (r_state)
            S_IDLE: begin
                // gated by rst_n so nothing looks accepted while reset is held
                if (rst_n && (req_valid != 2'b00)) begin
                    w_accept    = 1'b1;
                    req_ready   = w_grant_id ? 2'b10 : 2'b01;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: w_state_nxt = S_RESP;
            S_RESP: begin
                rsp_valid = r_owner ? 2'b10 : 2'b01;
                if (rsp_ready[r_owner]) begin
                    w_rsp_done  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr   <= ~RR_INIT;
            r_owner <= 1'b0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_op    <= 3'd0;
            r_z     <= 32'd0;
            r_zero  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_owner <= w_grant_id;
                r_a     <= w_grant_id ? req_a1  : req_a0;
                r_b     <= w_grant_id ? req_b1  : req_b0;
                r_op    <= w_grant_id ? req_op1 : req_op0;
            end
            if (r_state == S_EXEC) begin
                r_z    <= w_z;
                r_zero <= w_ex;
            end
            if (w_rsp_done) r_ptr <= r_owner;
        end
    end

    assign rsp_z    = r_z;
    assign rsp_zero = r_zero;

`ifdef ALU_ARB_GRANT_CNT_EN
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (w_accept) begin
            if (!w_grant_id && (r_cnt0 != {CNT_W{1'b1}})) r_cnt0 <= r_cnt0 + CNT_W'(1);
            if (w_grant_id && (r_cnt1 != {CNT_W{1'b1}}))  r_cnt1 <= r_cnt1 + CNT_W'(1);
        end
    end

    assign grant_cnt0 = r_cnt0;
    assign grant_cnt1 = r_cnt1;
`endif
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: driver predicts grants and results,
// a separate monitor checks every presented response.
module tb_alu_share_arbiter;
`ifdef ALU_ARB_GRANT_CNT_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 16;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [31:0] req_a0, req_b0, req_a1, req_b1, rsp_z;
    logic [2:0]  req_op0, req_op1;
    logic        rsp_zero;
`ifdef ALU_ARB_GRANT_CNT_EN
    logic [CNT_W-1:0] grant_cnt0, grant_cnt1;
`endif

    alu_share_arbiter #(.RR_INIT(1'b0), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_b0(req_b0), .req_op0(req_op0),
        .req_a1(req_a1), .req_b1(req_b1), .req_op1(req_op1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_z(rsp_z), .rsp_zero(rsp_zero)
`ifdef ALU_ARB_GRANT_CNT_EN
        , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          id;
        logic [31:0] z;
        logic        zero;
        int          acc;
        bit          seen;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   last_id = 1'b1;
    int   gcnt0 = 0;
    int   gcnt1 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [2:0] rand_op();
        case ($urandom_range(0, 4))
            0:       return 3'b000;
            1:       return 3'b001;
            2:       return 3'b010;
            3:       return 3'b110;
            default: return 3'b111;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One cycle: inputs already driven; predict acceptance, push expected result.
    task automatic step(input logic [1:0] rr, output bit acc);
        logic [1:0] exp_rdy;
        bit         g;
        logic [31:0] z;
        rsp_ready = rr;
        acc = 1'b0;
        @(negedge clk);
        exp_rdy = 2'b00;
        g = 1'b0;
        if (rst_n && sb.size() == 0 && req_valid != 2'b00) begin
            g = (req_valid == 2'b11) ? ~last_id : req_valid[1];
            exp_rdy = g ? 2'b10 : 2'b01;
        end
        chk("req_ready", {30'd0, req_ready}, {30'd0, exp_rdy});
        if (exp_rdy != 2'b00) begin
            z = g ? ref_alu(req_a1, req_b1, req_op1) : ref_alu(req_a0, req_b0, req_op0);
            sb.push_back('{id: g, z: z, zero: (z == 32'd0), acc: cyc, seen: 1'b0});
            if (g) gcnt1++; else gcnt0++;
            acc = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit id, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic [1:0] rr);
        bit acc;
        int n;
        if (id) begin req_a1 = a; req_b1 = b; req_op1 = op; req_valid = 2'b10; end
        else    begin req_a0 = a; req_b0 = b; req_op0 = op; req_valid = 2'b01; end
        n = 0;
        acc = 1'b0;
        while (!acc && n < 20) begin
            step(rr, acc);
            n++;
        end
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        req_valid = 2'b00;
        // operands change after acceptance; latched values must be used
        req_a0 = $urandom; req_b0 = $urandom; req_a1 = $urandom; req_b1 = $urandom;
        req_op0 = rand_op(); req_op1 = rand_op();
    endtask

    task automatic drain(input logic [1:0] rr);
        bit acc;
        int n;
        n = 0;
        req_valid = 2'b00;
        while (sb.size() != 0 && n < 30) begin
            step(rr, acc);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    // Monitor: compares every presented response with the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid != 2'b00) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", {30'd0, rsp_valid}, 32'd0);
                end else begin
                    e = sb[0];
                    chk("rsp_valid", {30'd0, rsp_valid}, e.id ? 32'd2 : 32'd1);
                    chk("rsp_z", rsp_z, e.z);
                    chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, e.zero});
                    chk("req_ready_busy", {30'd0, req_ready}, 32'd0);
                    if (!e.seen) begin
                        chk("latency", cyc - e.acc, 32'd2);
                        sb[0].seen = 1'b1;
                    end
                    if (rsp_ready[e.id]) begin
                        @(posedge clk);
                        last_id = e.id;
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        bit acc;
        int n, got;
        rst_n = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 2'b00;
        req_a0 = 32'd1; req_b0 = 32'd2; req_op0 = 3'b010;
        req_a1 = 32'd3; req_b1 = 32'd4; req_op1 = 3'b010;
        @(posedge clk);
        #1;
        repeat (2) begin
            step(2'b11, acc);
            chk("reset_rsp_valid", {30'd0, rsp_valid}, 32'd0);
            chk("reset_rsp_z", rsp_z, 32'd0);
            chk("reset_rsp_zero", {31'd0, rsp_zero}, 32'd0);
        end
        req_valid = 2'b00;
        rst_n = 1'b1;

        issue(1'b0, 32'd5, 32'd3, 3'b010, 2'b11);
        drain(2'b11);
        issue(1'b1, 32'd7, 32'd7, 3'b110, 2'b11);
        drain(2'b11);
        issue(1'b1, 32'hFFFF_FFFF, 32'd1, 3'b111, 2'b11);
        drain(2'b11);
        issue(1'b1, 32'hFFFF_FFFF, 32'd1, 3'b010, 2'b11);
        drain(2'b11);
        issue(1'b0, 32'h8000_0000, 32'd1, 3'b111, 2'b11);
        drain(2'b11);

        // both requesters permanently valid: grants must alternate
        req_valid = 2'b11;
        got = 0;
        n = 0;
        while (got < 8 && n < 60) begin
            req_a0 = $urandom; req_b0 = $urandom; req_op0 = rand_op();
            req_a1 = $urandom; req_b1 = $urandom; req_op1 = rand_op();
            step(2'b11, acc);
            if (acc) got++;
            n++;
        end
        chk("both_valid_grants", got, 8);
        drain(2'b11);

        // owner stalls; non-owner ready must be ignored
        issue(1'b1, 32'hF0F0_1234, 32'h0FF0_FFFF, 3'b000, 2'b01);
        req_valid = 2'b11;
        repeat (7) step(2'b01, acc);
        step(2'b10, acc);
        step(2'b11, acc);
        chk("grant_after_release", {31'd0, acc}, 32'd1);
        drain(2'b11);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            req_valid = 2'($urandom_range(0, 3));
            req_a0 = $urandom; req_op0 = rand_op();
            req_b0 = ($urandom_range(0, 3) == 0) ? req_a0 : $urandom;
            req_a1 = $urandom_range(0, 20); req_op1 = rand_op();
            req_b1 = ($urandom_range(0, 3) == 0) ? req_a1 : 32'($urandom_range(0, 20));
            step(2'($urandom_range(0, 3)), acc);
        end
        drain(2'b11);

        // reset while executing abandons the operation
        issue(1'b0, 32'd9, 32'd9, 3'b010, 2'b11);
        rst_n = 1'b0;
        sb.delete();
        last_id = 1'b1;
        gcnt0 = 0;
        gcnt1 = 0;
        step(2'b11, acc);
        rst_n = 1'b1;
        repeat (4) begin
            step(2'b11, acc);
            chk("abandon_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        end

        repeat (5) begin
            issue(1'b0, $urandom, $urandom, rand_op(), 2'b11);
            drain(2'b11);
        end
`ifdef ALU_ARB_GRANT_CNT_EN
        chk("grant_cnt0", {{(32-CNT_W){1'b0}}, grant_cnt0},
            (gcnt0 > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : gcnt0);
        chk("grant_cnt1", {{(32-CNT_W){1'b0}}, grant_cnt1},
            (gcnt1 > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : gcnt1);
`endif
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
